// File: rtl/hbm_bench_pkg.sv
// Shared types and AXI3 constants for the HBM pseudo-channel bench controller.
package hbm_bench_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_WR    = 2'b01;
  localparam logic [1:0] MODE_RD    = 2'b10;
  localparam logic [1:0] MODE_WR_RD = 2'b11;

  localparam logic [2:0] SIZE_32B      = 3'b101;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  function automatic logic mode_has_wr(input logic [1:0] m);
    return (m == MODE_WR) || (m == MODE_WR_RD);
  endfunction

  function automatic logic mode_has_rd(input logic [1:0] m);
    return !((m == MODE_NOP) || (m == MODE_WR));
  endfunction

endpackage

// File: rtl/hbm_bench_pattern.sv
// Combinational data pattern: 32-bit word k of a beat is beat_addr + k.
module hbm_bench_pattern #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic [31:0]           beat_addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned WORDS = DATA_WIDTH / 32;

  always_comb begin
    data = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      data[k*32 +: 32] = beat_addr + 32'(k);
    end
  end

endmodule

// File: rtl/hbm_bench_ctrl.sv
// AXI3 write/read traffic generator for one HBM pseudo-channel, one burst in flight.
// Define HBM_BENCH_CHECK_EN to build the read-data comparator behind err_cnt.
module hbm_bench_ctrl
  import hbm_bench_pkg::*;
#(
  parameter int unsigned         ID_WIDTH   = 6,
  parameter int unsigned         ADDR_WIDTH = 33,
  parameter int unsigned         DATA_WIDTH = 256,
  parameter int unsigned         CNT_WIDTH  = 32,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [15:0]             num_bursts,
  input  logic [3:0]              burst_len,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    wr_cycles,
  output logic [CNT_WIDTH-1:0]    rd_cycles,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic                    resp_err,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [1:0]              m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ID_WIDTH-1:0]     m_axi_wid,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [3:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [1:0]              m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [15:0]             nb_q, nb_d;
  logic [3:0]              len_q, len_d;
  logic [15:0]             idx_q, idx_d;
  logic [3:0]              beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    wr_cyc_q, wr_cyc_d;
  logic [CNT_WIDTH-1:0]    rd_cyc_q, rd_cyc_d;
  logic                    resp_err_q, resp_err_d;

  logic [ADDR_WIDTH-1:0]   stride;
  logic [31:0]             beat_addr;
  logic [DATA_WIDTH-1:0]   pattern;
  logic                    last_burst;
  logic                    in_wr;
  logic                    in_rd;
  logic                    unused_sig;

  assign stride     = (ADDR_WIDTH'({1'b0, len_q} + 5'd1)) << 5;
  assign beat_addr  = addr_q[31:0] + {23'd0, beat_q, 5'd0};
  assign last_burst = (idx_q == nb_q - 16'd1);
  assign in_wr      = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == WR_RESP);
  assign in_rd      = (state_q == RD_ADDR) || (state_q == RD_DATA);

  // One generator serves both phases: addr_q/beat_q track whichever burst is active.
  hbm_bench_pattern #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .beat_addr(beat_addr),
    .data     (pattern)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    nb_d       = nb_q;
    len_d      = len_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    wr_cyc_d   = wr_cyc_q;
    rd_cyc_d   = rd_cyc_q;
    resp_err_d = resp_err_q;

    if (in_wr && (wr_cyc_q != '1)) wr_cyc_d = wr_cyc_q + CNT_WIDTH'(1);
    if (in_rd && (rd_cyc_q != '1)) rd_cyc_d = rd_cyc_q + CNT_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          base_d     = base_addr;
          nb_d       = num_bursts;
          len_d      = burst_len;
          idx_d      = '0;
          beat_d     = '0;
          addr_d     = base_addr;
          wr_cyc_d   = '0;
          rd_cyc_d   = '0;
          resp_err_d = 1'b0;
          if (mode_has_wr(mode) && (num_bursts != '0))      state_d = WR_ADDR;
          else if (mode_has_rd(mode) && (num_bursts != '0)) state_d = RD_ADDR;
          else                                              state_d = DONE;
        end
      end
      WR_ADDR: begin
        if (m_axi_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (m_axi_wready) begin
          if (beat_q == len_q) begin
            beat_d  = '0;
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) resp_err_d = 1'b1;
          if (last_burst) begin
            idx_d   = '0;
            addr_d  = base_q;
            state_d = mode_has_rd(mode_q) ? RD_ADDR : DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            addr_d  = addr_q + stride;
            state_d = WR_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != RESP_OKAY) resp_err_d = 1'b1;
          if (m_axi_rlast) begin
            beat_d = '0;
            if (last_burst) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 16'd1;
              addr_d  = addr_q + stride;
              state_d = RD_ADDR;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      nb_q       <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      wr_cyc_q   <= '0;
      rd_cyc_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      nb_q       <= nb_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      wr_cyc_q   <= wr_cyc_d;
      rd_cyc_q   <= rd_cyc_d;
      resp_err_q <= resp_err_d;
    end
  end

`ifdef HBM_BENCH_CHECK_EN
  logic [CNT_WIDTH-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = '0;
    end else if ((state_q == RD_DATA) && m_axi_rvalid && (m_axi_rdata != pattern)
                 && (err_q != '1)) begin
      err_d = err_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_cnt    = err_q;
  assign unused_sig = ^{m_axi_bid, m_axi_rid};
`else
  assign err_cnt    = '0;
  assign unused_sig = ^{m_axi_bid, m_axi_rid, m_axi_rdata};
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign wr_cycles = wr_cyc_q;
  assign rd_cycles = rd_cyc_q;
  assign resp_err  = resp_err_q;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = SIZE_32B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = '0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_awvalid = (state_q == WR_ADDR);

  assign m_axi_wid     = AXI_ID;
  assign m_axi_wdata   = pattern;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == WR_DATA);
  assign m_axi_wlast   = m_axi_wvalid && (beat_q == len_q);
  assign m_axi_bready  = (state_q == WR_RESP);

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = SIZE_32B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = '0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_hbm_bench_ctrl.sv
// Scoreboard bench for hbm_bench_ctrl with a memory-backed AXI3 slave model.
module tb_hbm_bench_ctrl;

  localparam int unsigned IDW = 6;
  localparam int unsigned AW  = 33;
  localparam int unsigned DW  = 256;
  localparam int unsigned CW  = 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic start;
  logic [1:0] mode;
  logic [AW-1:0] base_addr;
  logic [15:0] num_bursts;
  logic [3:0] burst_len;
  logic busy, done, resp_err;
  logic [CW-1:0] wr_cycles, rd_cycles, err_cnt;
  logic [IDW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0] awlen, awcache, awqos, arlen, arcache, arqos;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, awlock, arburst, arlock, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  always #5 aclk = ~aclk;

  hbm_bench_ctrl #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .AXI_ID('0)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .busy(busy), .done(done),
    .wr_cycles(wr_cycles), .rd_cycles(rd_cycles), .err_cnt(err_cnt), .resp_err(resp_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: event occurred with no expectation pending", name);
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = a + 32'(k);
    return d;
  endfunction

  // ---------------- scoreboard queues ----------------
  typedef struct { logic [DW-1:0] data; logic last; } wexp_t;
  typedef struct { bit chk_cyc; int unsigned wr; int unsigned rd; bit rd_nz; int unsigned err; bit rerr; } res_t;

  logic [AW-1:0] exp_aw_q[$];
  logic [AW-1:0] exp_ar_q[$];
  wexp_t         exp_w_q[$];
  res_t          exp_res_q[$];
  logic [AW-1:0] aw_log[$];
  logic [AW-1:0] ar_log[$];
  logic [31:0]   w0_log[$];
  logic          wl_log[$];
  logic [3:0]    cur_len;
  logic [DW/8-1:0] all_ones = '1;
  int w_hs_cnt = 0, done_cnt = 0, valid_seen = 0;

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit bp_en = 0, inj_bresp = 0;
  int inj_flip_beat = -1, rd_beat_global = 0;
  logic [AW-1:0] s_waddr, s_raddr, c_awaddr, c_araddr, ra;
  logic [DW-1:0] c_wdata;
  logic [3:0] c_arlen;
  int s_wbeat = 0, s_rbeat = 0, s_rlen = 0;
  bit s_ractive = 0, h_aw, h_w, h_b, h_ar, h_r;

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    forever begin
      @(negedge aclk);
      h_aw = awvalid && awready; c_awaddr = awaddr;
      h_w  = wvalid && wready;   c_wdata  = wdata;
      h_b  = bvalid && bready;
      h_ar = arvalid && arready; c_araddr = araddr; c_arlen = arlen;
      h_r  = rvalid && rready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        s_ractive = 0; s_wbeat = 0; s_rbeat = 0;
      end else begin
        if (h_aw) begin s_waddr = c_awaddr; s_wbeat = 0; end
        if (h_w) begin mem[s_waddr + AW'(s_wbeat * 32)] = c_wdata; s_wbeat++; end
        if (h_b) inj_bresp = 0;
        if (h_ar) begin
          s_raddr = c_araddr; s_rlen = int'(c_arlen); s_rbeat = 0; s_ractive = 1;
        end else if (h_r) begin
          rd_beat_global++;
          if (s_rbeat == s_rlen) s_ractive = 0;
          else s_rbeat++;
        end
      end
      awready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
      wready  = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
      bvalid  = 1'b1;
      bresp   = inj_bresp ? 2'b10 : 2'b00;
      arready = 1'b1;
      if (s_ractive) begin
        ra = s_raddr + AW'(s_rbeat * 32);
        rdata = mem.exists(ra) ? mem[ra] : '0;
        if (rd_beat_global == inj_flip_beat) rdata[0] = ~rdata[0];
        rlast = (s_rbeat == s_rlen);
        rvalid = 1'b1;
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit p_aw_stall = 0, p_w_stall = 0, p_ar_stall = 0, p_wlast;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  wexp_t we;
  res_t  re;

  always @(negedge aclk) begin
    if (!aresetn) begin
      p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0;
    end else begin
      if (awvalid || wvalid || arvalid) valid_seen++;
      if (p_aw_stall) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w_stall)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
      if (p_ar_stall) check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (awvalid && awready) begin
        aw_log.push_back(awaddr);
        check("aw_fields", {awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid},
              {cur_len, 3'b101, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 6'd0});
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else check("awaddr", awaddr, exp_aw_q.pop_front());
      end
      if (wvalid && wready) begin
        w_hs_cnt++;
        w0_log.push_back(wdata[31:0]);
        wl_log.push_back(wlast);
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else begin
          we = exp_w_q.pop_front();
          check("w_beat", {wstrb, wlast, wdata}, {all_ones, we.last, we.data});
        end
      end
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        check("ar_fields", {arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid},
              {cur_len, 3'b101, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 6'd0});
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else check("araddr", araddr, exp_ar_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) fail_now("done_unexpected");
        else begin
          re = exp_res_q.pop_front();
          if (re.chk_cyc) begin
            check("wr_cycles", wr_cycles, re.wr);
            check("rd_cycles", rd_cycles, re.rd);
          end else if (re.rd_nz) begin
            check("rd_cycles_nonzero", rd_cycles != 0, 1'b1);
          end
          check("err_cnt", err_cnt, re.err);
          check("resp_err", resp_err, re.rerr);
        end
      end
      p_aw_stall = awvalid && !awready; p_awaddr = awaddr;
      p_w_stall  = wvalid && !wready;   p_wdata  = wdata; p_wlast = wlast;
      p_ar_stall = arvalid && !arready; p_araddr = araddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [1:0] md, input logic [AW-1:0] base,
                          input logic [15:0] nb, input logic [3:0] len);
    logic [AW-1:0] a, ba;
    wexp_t e;
    cur_len = len;
    if (nb == 0) return;
    for (int b = 0; b < int'(nb); b++) begin
      a = base + AW'(b * (int'(len) + 1) * 32);
      if (md[0]) begin
        exp_aw_q.push_back(a);
        for (int t = 0; t <= int'(len); t++) begin
          ba = a + AW'(t * 32);
          e.data = pat(ba[31:0]);
          e.last = (t == int'(len));
          exp_w_q.push_back(e);
        end
      end
      if (md[1]) exp_ar_q.push_back(a);
    end
  endtask

  task automatic pulse_start(input logic [1:0] md, input logic [AW-1:0] base,
                             input logic [15:0] nb, input logic [3:0] len);
    @(posedge aclk);
    #1;
    mode = md; base_addr = base; num_bursts = nb; burst_len = len; start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0; mode = ~md; base_addr = ~base; num_bursts = ~nb; burst_len = ~len;
  endtask

  task automatic run(input logic [1:0] md, input logic [AW-1:0] base, input logic [15:0] nb,
                     input logic [3:0] len, input bit chk, input int unsigned wr,
                     input int unsigned rd, input int unsigned err, input bit rerr,
                     input bit extra, output int unsigned lat);
    res_t r;
    int w0, d0, cyc;
    aw_log.delete(); ar_log.delete(); w0_log.delete(); wl_log.delete();
    push_exp(md, base, nb, len);
    r.chk_cyc = chk; r.wr = wr; r.rd = rd; r.rd_nz = md[1] && (nb != 0);
    r.err = err; r.rerr = rerr;
    exp_res_q.push_back(r);
    w0 = w_hs_cnt; d0 = done_cnt;
    pulse_start(md, base, nb, len);
    if (extra) begin
      repeat (4) @(posedge aclk);
      #1;
      start = 1'b1; mode = 2'b01; num_bursts = 16'd7; base_addr = 33'h1_2345_6780;
      @(posedge aclk);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(posedge aclk);
      cyc++;
    end
    lat = cyc;
    if (done_cnt == d0) begin
      n_checks++; n_fails++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
    repeat (3) @(posedge aclk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_done", busy, 1'b0);
    check("w_beat_count", w_hs_cnt - w0, (md[0] && nb != 0) ? int'(nb) * (int'(len) + 1) : 0);
    check("queues_drained", {exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_res_q.size()}, '0);
  endtask

  int unsigned lat;
  int v0, w0, cyc;
  logic [7:0] wl_mask;

  initial begin
    start = 1'b0; mode = 2'b00; base_addr = '0; num_bursts = '0; burst_len = '0; cur_len = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, '0);
    check("reset_status", {busy, done, resp_err}, '0);
    check("reset_counters", {wr_cycles, rd_cycles, err_cnt}, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // plain write: 2 bursts of 4 beats
    run(2'b01, 33'h0, 16'd2, 4'd3, 1, 12, 0, 0, 0, 0, lat);
    check("t1_aw_count", aw_log.size(), 2);
    if (aw_log.size() == 2) check("t1_aw_addrs", {aw_log[0], aw_log[1]}, {33'h0, 33'h80});
    if (w0_log.size() == 8) begin
      check("t1_beat1_word0", w0_log[1], 32'h20);
      for (int i = 0; i < 8; i++) wl_mask[i] = wl_log[i];
      check("t1_wlast_pos", wl_mask, 8'b1000_1000);
    end else begin
      check("t1_w_log_size", w0_log.size(), 8);
    end

    // write then read, with a start mid-run that must be ignored
    run(2'b11, 33'h4000, 16'd3, 4'd3, 1, 18, 15, 0, 0, 1, lat);
    check("t2_ar_eq_aw", {ar_log.size(), ar_log.size() == aw_log.size() && ar_log == aw_log}, {32'd3, 1'b1});

    // write/read under AW/W back-pressure
    bp_en = 1;
    run(2'b11, 33'h1_0000, 16'd4, 4'd7, 0, 0, 0, 0, 0, 0, lat);
    bp_en = 0;

    // bad bresp once, one corrupted read beat
    inj_bresp = 1;
    inj_flip_beat = rd_beat_global + 2;
`ifdef HBM_BENCH_CHECK_EN
    run(2'b11, 33'h2000, 16'd2, 4'd1, 1, 8, 6, 1, 1, 0, lat);
`else
    run(2'b11, 33'h2000, 16'd2, 4'd1, 1, 8, 6, 0, 1, 0, lat);
`endif
    inj_flip_beat = -1;

    // zero bursts: straight to DONE, no traffic
    v0 = valid_seen;
    run(2'b11, 33'h0, 16'd0, 4'd3, 1, 0, 0, 0, 0, 0, lat);
    check("nb0_done_latency_le2", lat <= 2, 1'b1);
    check("nb0_no_valids", valid_seen - v0, 0);

    // address wrap at 2^33
    run(2'b01, 33'h1_FFFF_FFE0, 16'd2, 4'd0, 1, 6, 0, 0, 0, 0, lat);
    if (aw_log.size() == 2) check("wrap_aw_addrs", {aw_log[0], aw_log[1]}, {33'h1_FFFF_FFE0, 33'h0});
    else check("wrap_aw_count", aw_log.size(), 2);

    // reset mid-WR_DATA
    bp_en = 1;
    push_exp(2'b01, 33'h3000, 16'd2, 4'd7);
    w0 = w_hs_cnt;
    pulse_start(2'b01, 33'h3000, 16'd2, 4'd7);
    cyc = 0;
    while (w_hs_cnt - w0 < 3 && cyc < 2000) begin
      @(posedge aclk);
      cyc++;
    end
    if (w_hs_cnt - w0 < 3) begin
      n_checks++; n_fails++;
      $display("FAIL midburst_timeout: only %0d W beats", w_hs_cnt - w0);
    end
    @(negedge aclk);
    #2;
    check("pre_reset_wvalid", wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("midrst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, '0);
    check("midrst_status", {busy, done, resp_err}, '0);
    check("midrst_counters", {wr_cycles, rd_cycles, err_cnt}, '0);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_res_q.delete();
    bp_en = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    run(2'b01, 33'h800, 16'd1, 4'd2, 1, 5, 0, 0, 0, 0, lat);
    if (aw_log.size() == 1) check("post_rst_aw", aw_log[0], 33'h800);
    else check("post_rst_aw_count", aw_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hbm_bench_ctrl.md
HBM_BENCH_CTRL -- requirements
Module: hbm_bench_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- ID_WIDTH, 6, AXI ID width
- ADDR_WIDTH, 33, byte address width
- DATA_WIDTH, 256, data bus width
- CNT_WIDTH, 32, width of the cycle and error counters
- AXI_ID, 0, constant awid/arid value
REQ-002 The block SHALL use one clock, aclk, and an asynchronous, active-low reset, aresetn.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- aclk, in, 1, clock
- aresetn, in, 1, async active-low reset
- start, in, 1, run request pulse
- mode, in, 2, run mode: 01 write, 10 read, 11 write then read, 00 no-op
- base_addr, in, ADDR_WIDTH, first burst byte address
- num_bursts, in, 16, bursts per phase
- burst_len, in, 4, AXI3 len (beats minus 1)
- busy, out, 1, run in progress
- done, out, 1, one-cycle completion pulse
- wr_cycles, out, CNT_WIDTH, write-phase cycle count
- rd_cycles, out, CNT_WIDTH, read-phase cycle count
- err_cnt, out, CNT_WIDTH, read-data mismatch beats
- resp_err, out, 1, sticky flag for bresp/rresp not equal to 00
- m_axi, AXI3 interface, -, master side of one HBM pseudo-channel

Function
REQ-004 The state machine SHALL use the states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-005 In IDLE, start=1 SHALL latch mode, base_addr, num_bursts and burst_len, clear all counters and resp_err, and set busy=1 on the next cycle.
REQ-006 The block SHALL ignore start in every state other than IDLE.
REQ-007 After start, the block SHALL go to WR_ADDR when mode[0]=1 and num_bursts is not 0, otherwise to RD_ADDR when mode[1]=1 and num_bursts is not 0, otherwise to DONE.
REQ-008 The block SHALL keep at most one burst outstanding: AW handshake, then all W beats, then B handshake, then the next AW.
REQ-009 Address fields SHALL be fixed as follows:
- awsize/arsize = 3'b101
- awburst/arburst = 2'b01
- awlock/arlock = 0
- awcache/arcache = 4'b0011
- prot = 0
- qos = 0
- wstrb = all ones
REQ-010 Burst n SHALL use address base_addr + n*(burst_len+1)*32, taken modulo 2^ADDR_WIDTH (wraps silently).
REQ-011 Every valid SHALL stay high, with a stable payload, until its ready handshake completes.
REQ-012 wlast SHALL be 1 only on beat number burst_len.
REQ-013 The 32-bit word k of the data on a beat SHALL equal beat_addr[31:0] + k, where beat_addr = burst address + beat*32.
REQ-014 After the last B handshake, the block SHALL go to RD_ADDR when mode[1]=1, otherwise to DONE.
REQ-015 During RD_DATA, rready SHALL be held at 1.
REQ-016 A burst SHALL end on an R handshake with rlast=1, and the last burst SHALL lead to DONE.
REQ-017 wr_cycles SHALL count every cycle spent in WR_ADDR, WR_DATA or WR_RESP, and rd_cycles every cycle spent in RD_ADDR or RD_DATA; both SHALL saturate at their maximum value.
REQ-018 Any bresp or rresp not equal to 00 on a handshake SHALL set resp_err until the next accepted start.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE with busy=0.
REQ-020 The counters SHALL keep their values until the next accepted start.

Reset
REQ-021 aresetn=0 SHALL, asynchronously:
- force the state to IDLE
- clear all valids, wlast, rready, busy, done, resp_err and all counters
- take effect even mid-burst, with no completion of the burst
REQ-022 The first accepted start after reset SHALL behave exactly like one from a clean IDLE.

Configuration
REQ-023 With the macro HBM_BENCH_CHECK_EN defined:
- each R beat SHALL be compared against the REQ-013 pattern
- err_cnt SHALL count mismatching beats, saturating at its maximum
REQ-024 Without HBM_BENCH_CHECK_EN:
- no comparator logic SHALL be built
- err_cnt SHALL be tied to 0
- read data SHALL be discarded

Structure
REQ-025 The package hbm_bench_pkg SHALL hold:
- the state enum
- the mode encodings
- the AXI constants: SIZE_32B, BURST_INCR, CACHE_DEFAULT and RESP_OKAY
REQ-026 The sub-module hbm_bench_pattern SHALL be a combinational generator from beat_addr to the DATA_WIDTH pattern, shared by the write and check paths.

Verification
REQ-027 Write, with mode=01, base=0, num_bursts=2, burst_len=3, and awready/wready/bvalid always 1:
- AW addresses SHALL be 0x0 and 0x80
- 8 W beats SHALL be sent, with wlast on beats 3 and 7
- beat 1 of burst 0, word 0 SHALL be 0x20
- done SHALL pulse once, and wr_cycles SHALL be the cycle count
REQ-028 Write then read, with mode=11 and a memory model that returns the data it was written:
- err_cnt SHALL be 0
- resp_err SHALL be 0
- rd_cycles SHALL be greater than 0
- the AR sequence SHALL equal the AW sequence
REQ-029 Back-pressure, with awready/wready driven by a random 30% duty cycle:
- payloads SHALL stay stable while valid=1 and ready=0
- the beat count SHALL be unchanged
REQ-030 Errors, with the model flipping rdata bit 0 on one beat and returning bresp=2'b10 once:
- err_cnt SHALL be 1 (with HBM_BENCH_CHECK_EN)
- resp_err SHALL be 1
REQ-031 Edge cases:
- num_bursts=0 with mode=11 SHALL go to DONE within 2 cycles of start, with no AXI valids
- base=0x1_FFFF_FFE0 with burst_len=0 SHALL give a second burst address of 0x0
REQ-032 aresetn low mid-WR_DATA SHALL clear all valids in the same cycle, with busy=0, and a new start afterwards SHALL complete normally.
